// File: rtl/sa_tile_scheduler_pkg.sv
// Shared types for the systolic-array tile scheduler: descriptor type,
// descriptor record and the default tile limit.
package sa_tile_scheduler_pkg;

   localparam int SA_MAX_TILE = 16;
   localparam int SA_DIM_W    = 16;

   typedef enum logic [1:0] {
      DESC_LOAD_A  = 2'd0,
      DESC_LOAD_B  = 2'd1,
      DESC_COMPUTE = 2'd2,
      DESC_STORE_C = 2'd3
   } desc_type_e;

   typedef struct packed {
      desc_type_e            dtype;
      logic [31:0]           addr;
      logic [31:0]           stride;
      logic [SA_DIM_W-1:0]   rows;
      logic [SA_DIM_W-1:0]   cols;
   } sa_desc_t;

endpackage

// File: rtl/sa_tile_scheduler_if.sv
// Descriptor bus between the tile scheduler and the datapath/DMA consumer.
interface sa_tile_scheduler_if #(
   parameter int DIM_W = 16
);
   logic             desc_valid;
   logic             desc_ready;
   logic [1:0]       desc_type;
   logic [31:0]      desc_addr;
   logic [31:0]      desc_stride;
   logic [DIM_W-1:0] desc_rows;
   logic [DIM_W-1:0] desc_cols;
   logic             op_done;

   modport master (
      output desc_valid, desc_type, desc_addr, desc_stride, desc_rows, desc_cols,
      input  desc_ready, op_done
   );

   modport slave (
      input  desc_valid, desc_type, desc_addr, desc_stride, desc_rows, desc_cols,
      output desc_ready, op_done
   );
endinterface

// File: rtl/sa_tile_scheduler_addr_gen.sv
// Tile walker: m/n/k counters, row-offset accumulators and edge clipping.
// Presents the current descriptor and flags the final STORE_C.
module sa_tile_addr_gen
   import sa_tile_scheduler_pkg::*;
#(
   parameter int DATA_BYTES = 1,
   parameter int DIM_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             init,
   input  logic             adv,
   input  logic             update_a,
   input  logic [DIM_W-1:0] cfg_n,
   input  logic [DIM_W-1:0] cfg_k,
   input  logic [DIM_W-1:0] cfg_m,
   input  logic [DIM_W-1:0] cfg_tile_size,
   input  logic [DIM_W-1:0] cfg_block_m,
   input  logic [31:0]      cfg_base_a,
   input  logic [31:0]      cfg_base_b,
   input  logic [31:0]      cfg_base_c,
   input  logic [31:0]      cfg_stride_a,
   input  logic [31:0]      cfg_stride_b,
   input  logic [31:0]      cfg_stride_c,
   output sa_desc_t         desc,
   output logic             last
);

   localparam logic [31:0] DATA_BYTES_U = DATA_BYTES;

   logic [DIM_W-1:0] n_q, k_q, m_q, t_q, bm_q;
   logic             upd_q;
   logic [31:0]      base_a_q, base_b_q, base_c_q;
   logic [31:0]      stride_a_q, stride_b_q, stride_c_q;
   logic [31:0]      step_a, step_b, step_c;
   logic [DIM_W-1:0] m_cnt, n_cnt, k_cnt;
   logic [31:0]      acc_a, acc_b, acc_c;
   desc_type_e       phase;

   logic             last_m, last_n, last_k;
   logic [DIM_W-1:0] rem_m, rem_n, rem_k;
   logic [DIM_W-1:0] mr, nc, kc;
   logic [31:0]      col_k, col_n;

   // Widen by one bit so a step past the end of a 2^DIM_W range still compares right.
   assign last_m = ({1'b0, m_cnt} + {1'b0, bm_q}) >= {1'b0, m_q};
   assign last_n = ({1'b0, n_cnt} + {1'b0, t_q})  >= {1'b0, n_q};
   assign last_k = ({1'b0, k_cnt} + {1'b0, t_q})  >= {1'b0, k_q};

   assign rem_m = m_q - m_cnt;
   assign rem_n = n_q - n_cnt;
   assign rem_k = k_q - k_cnt;
   assign mr    = (bm_q < rem_m) ? bm_q : rem_m;
   assign nc    = (t_q  < rem_n) ? t_q  : rem_n;
   assign kc    = (t_q  < rem_k) ? t_q  : rem_k;

   assign col_k = 32'(k_cnt) * DATA_BYTES_U;
   assign col_n = 32'(n_cnt) * DATA_BYTES_U;

   assign last  = (phase == DESC_STORE_C) && last_n && last_m;

   // Latch config and row steps on init; walk the loop nest one descriptor per advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_q        <= '0;
         k_q        <= '0;
         m_q        <= '0;
         t_q        <= '0;
         bm_q       <= '0;
         upd_q      <= 1'b0;
         base_a_q   <= '0;
         base_b_q   <= '0;
         base_c_q   <= '0;
         stride_a_q <= '0;
         stride_b_q <= '0;
         stride_c_q <= '0;
         step_a     <= '0;
         step_b     <= '0;
         step_c     <= '0;
         m_cnt      <= '0;
         n_cnt      <= '0;
         k_cnt      <= '0;
         acc_a      <= '0;
         acc_b      <= '0;
         acc_c      <= '0;
         phase      <= DESC_LOAD_A;
      end else if (init) begin
         n_q        <= cfg_n;
         k_q        <= cfg_k;
         m_q        <= cfg_m;
         t_q        <= cfg_tile_size;
         bm_q       <= cfg_block_m;
         upd_q      <= update_a;
         base_a_q   <= cfg_base_a;
         base_b_q   <= cfg_base_b;
         base_c_q   <= cfg_base_c;
         stride_a_q <= cfg_stride_a;
         stride_b_q <= cfg_stride_b;
         stride_c_q <= cfg_stride_c;
         step_a     <= 32'(cfg_block_m) * cfg_stride_a;
         step_b     <= 32'(cfg_tile_size) * cfg_stride_b;
         step_c     <= 32'(cfg_block_m) * cfg_stride_c;
         m_cnt      <= '0;
         n_cnt      <= '0;
         k_cnt      <= '0;
         acc_a      <= '0;
         acc_b      <= '0;
         acc_c      <= '0;
         phase      <= update_a ? DESC_LOAD_A : DESC_LOAD_B;
      end else if (adv && !last) begin
         case (phase)
            DESC_LOAD_A: phase <= DESC_LOAD_B;
            DESC_LOAD_B: phase <= DESC_COMPUTE;
            DESC_COMPUTE: begin
               if (last_k) begin
                  phase <= DESC_STORE_C;
               end else begin
                  k_cnt <= k_cnt + t_q;
                  acc_b <= acc_b + step_b;
                  phase <= upd_q ? DESC_LOAD_A : DESC_LOAD_B;
               end
            end
            default: begin
               k_cnt <= '0;
               acc_b <= '0;
               phase <= upd_q ? DESC_LOAD_A : DESC_LOAD_B;
               if (last_n) begin
                  n_cnt <= '0;
                  m_cnt <= m_cnt + bm_q;
                  acc_a <= acc_a + step_a;
                  acc_c <= acc_c + step_c;
               end else begin
                  n_cnt <= n_cnt + t_q;
               end
            end
         endcase
      end
   end

   // Assemble the descriptor for the current phase; COMPUTE carries no address.
   always_comb begin
      desc       = '0;
      desc.dtype = phase;
      desc.rows  = SA_DIM_W'(mr);
      desc.cols  = SA_DIM_W'(nc);
      case (phase)
         DESC_LOAD_A: begin
            desc.addr   = base_a_q + acc_a + col_k;
            desc.stride = stride_a_q;
            desc.cols   = SA_DIM_W'(kc);
         end
         DESC_LOAD_B: begin
            desc.addr   = base_b_q + acc_b + col_n;
            desc.stride = stride_b_q;
            desc.rows   = SA_DIM_W'(kc);
         end
         DESC_STORE_C: begin
            desc.addr   = base_c_q + acc_c + col_n;
            desc.stride = stride_c_q;
         end
         default: begin
            desc.addr   = '0;
            desc.stride = '0;
         end
      endcase
   end

endmodule

// File: rtl/sa_tile_scheduler.sv
// Tile scheduler top: start validation, descriptor handshake FSM and
// busy/done/error/irq status around the tile walker.
module sa_tile_scheduler
   import sa_tile_scheduler_pkg::*;
#(
   parameter int DATA_BYTES = 1,
   parameter int MAX_TILE   = SA_MAX_TILE,
   parameter int DIM_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             update_a,
   input  logic             irq_en,
   input  logic [DIM_W-1:0] cfg_n,
   input  logic [DIM_W-1:0] cfg_k,
   input  logic [DIM_W-1:0] cfg_m,
   input  logic [DIM_W-1:0] cfg_tile_size,
   input  logic [DIM_W-1:0] cfg_block_m,
   input  logic [31:0]      cfg_base_a,
   input  logic [31:0]      cfg_base_b,
   input  logic [31:0]      cfg_base_c,
   input  logic [31:0]      cfg_stride_a,
   input  logic [31:0]      cfg_stride_b,
   input  logic [31:0]      cfg_stride_c,
   sa_tile_scheduler_if.master dbus,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic             irq
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_PREP  = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [31:0] MAX_TILE_U = MAX_TILE;

   logic [2:0] state;
   logic       done_q, error_q, irq_q;
   logic       cfg_bad;
   logic       gen_last;
   sa_desc_t   gen_desc, out_desc;

   assign cfg_bad = (cfg_n == '0) || (cfg_k == '0) || (cfg_m == '0) ||
                    (cfg_tile_size == '0) || (cfg_block_m == '0) ||
                    (32'(cfg_tile_size) > MAX_TILE_U) ||
                    (32'(cfg_block_m) > MAX_TILE_U);

   sa_tile_addr_gen #(
      .DATA_BYTES (DATA_BYTES),
      .DIM_W      (DIM_W)
   ) u_addr_gen (
      .clk           (clk),
      .rst_n         (rst_n),
      .init          (state == S_PREP),
      .adv           ((state == S_WAIT) && dbus.op_done),
      .update_a      (update_a),
      .cfg_n         (cfg_n),
      .cfg_k         (cfg_k),
      .cfg_m         (cfg_m),
      .cfg_tile_size (cfg_tile_size),
      .cfg_block_m   (cfg_block_m),
      .cfg_base_a    (cfg_base_a),
      .cfg_base_b    (cfg_base_b),
      .cfg_base_c    (cfg_base_c),
      .cfg_stride_a  (cfg_stride_a),
      .cfg_stride_b  (cfg_stride_b),
      .cfg_stride_c  (cfg_stride_c),
      .desc          (gen_desc),
      .last          (gen_last)
   );

   // Control FSM and sticky status; start is honoured only when not busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         irq_q <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               state <= S_IDLE;
               if (start) begin
                  done_q  <= 1'b0;
                  error_q <= 1'b0;
                  if (cfg_bad) begin
                     error_q <= 1'b1;
                     irq_q   <= irq_en;
                  end else begin
                     state <= S_PREP;
                  end
               end
            end
            S_PREP:  state <= S_ISSUE;
            S_ISSUE: if (dbus.desc_ready) state <= S_WAIT;
            S_WAIT: begin
               if (dbus.op_done) begin
                  if (gen_last) begin
                     state  <= S_DONE;
                     done_q <= 1'b1;
                     irq_q  <= irq_en;
                  end else begin
                     state <= S_ISSUE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Descriptor fields read as zero whenever nothing is offered.
   assign out_desc         = (state == S_ISSUE) ? gen_desc : '0;
   assign dbus.desc_valid  = (state == S_ISSUE);
   assign dbus.desc_type   = out_desc.dtype;
   assign dbus.desc_addr   = out_desc.addr;
   assign dbus.desc_stride = out_desc.stride;
   assign dbus.desc_rows   = DIM_W'(out_desc.rows);
   assign dbus.desc_cols   = DIM_W'(out_desc.cols);

   assign busy  = (state == S_PREP) || (state == S_ISSUE) || (state == S_WAIT);
   assign done  = done_q;
   assign error = error_q;
   assign irq   = irq_q;

endmodule

// File: tb/tb_sa_tile_scheduler.sv
// Directed, table-driven bench for the tile scheduler.
module tb_sa_tile_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        update_a = 1'b0;
   logic        irq_en = 1'b0;
   logic [15:0] cfg_n = '0, cfg_k = '0, cfg_m = '0, cfg_tile_size = '0, cfg_block_m = '0;
   logic [31:0] cfg_base_a = '0, cfg_base_b = '0, cfg_base_c = '0;
   logic [31:0] cfg_stride_a = '0, cfg_stride_b = '0, cfg_stride_c = '0;
   logic        busy, done, error, irq;

   sa_tile_scheduler_if #(.DIM_W(16)) bus ();

   sa_tile_scheduler #(.DATA_BYTES(1), .MAX_TILE(16), .DIM_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .update_a(update_a), .irq_en(irq_en),
      .cfg_n(cfg_n), .cfg_k(cfg_k), .cfg_m(cfg_m), .cfg_tile_size(cfg_tile_size),
      .cfg_block_m(cfg_block_m), .cfg_base_a(cfg_base_a), .cfg_base_b(cfg_base_b),
      .cfg_base_c(cfg_base_c), .cfg_stride_a(cfg_stride_a), .cfg_stride_b(cfg_stride_b),
      .cfg_stride_c(cfg_stride_c), .dbus(bus), .busy(busy), .done(done), .error(error),
      .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] n, k, m, t, bm;
      logic        upd, ien;
      logic [31:0] ba, bb, bc, sa, sb, sc;
      int          cnt;
   } cfg_t;

   typedef struct packed {
      logic [1:0]  ty;
      logic [31:0] addr;
      logic [31:0] stride;
      logic [15:0] rows;
      logic [15:0] cols;
   } cap_t;

   typedef struct {
      int   job;
      int   idx;
      cap_t d;
   } exp_t;

   cfg_t cfgs [3];
   exp_t exps [$];
   cap_t cap [5][32];
   int   ncap [5];
   int   n_chk = 0;
   int   n_fail = 0;
   int   irq_cnt = 0;

   always @(negedge clk) if (irq === 1'b1) irq_cnt++;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   function automatic cap_t snap();
      cap_t d;
      d.ty = bus.desc_type; d.addr = bus.desc_addr; d.stride = bus.desc_stride;
      d.rows = bus.desc_rows; d.cols = bus.desc_cols;
      return d;
   endfunction

   function automatic cap_t mk(input logic [1:0] ty, input logic [31:0] a, input logic [31:0] s,
                               input logic [15:0] r, input logic [15:0] c);
      cap_t d;
      d.ty = ty; d.addr = a; d.stride = s; d.rows = r; d.cols = c;
      return d;
   endfunction

   task automatic add_exp(input int job, input int idx, input cap_t d);
      exp_t e;
      e.job = job; e.idx = idx; e.d = d;
      exps.push_back(e);
   endtask

   task automatic apply_cfg(input int i);
      cfg_n = cfgs[i].n; cfg_k = cfgs[i].k; cfg_m = cfgs[i].m;
      cfg_tile_size = cfgs[i].t; cfg_block_m = cfgs[i].bm;
      update_a = cfgs[i].upd; irq_en = cfgs[i].ien;
      cfg_base_a = cfgs[i].ba; cfg_base_b = cfgs[i].bb; cfg_base_c = cfgs[i].bc;
      cfg_stride_a = cfgs[i].sa; cfg_stride_b = cfgs[i].sb; cfg_stride_c = cfgs[i].sc;
   endtask

   // Leaves the caller at #1 after the edge that sampled start (cycle t+1).
   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic run_job(input int job, input int stall, input bit restart,
                          input int exp_cnt, input logic exp_irq);
      cap_t d;
      int   guard = 0;
      int   stab_bad = 0;
      int   drop_bad = 0;
      int   irq0;
      bit   fin = 0;
      ncap[job] = 0;
      irq0 = irq_cnt;
      pulse_start();
      chk($sformatf("busy_t1_j%0d", job), busy, 1'b1);
      chk($sformatf("done_clr_j%0d", job), done, 1'b0);
      chk($sformatf("err_clr_j%0d", job), error, 1'b0);
      @(posedge clk); #1;
      chk($sformatf("valid_t2_j%0d", job), bus.desc_valid, 1'b1);
      while (!fin && guard < 400) begin
         guard++;
         if (bus.desc_valid) begin
            d = snap();
            if (ncap[job] < 32) cap[job][ncap[job]] = d;
            ncap[job]++;
            if (ncap[job] == 1) begin
               for (int s = 0; s < stall; s++) begin
                  if (restart && s == 1) begin
                     start = 1'b1;
                     cfg_base_a = 32'hDEAD0000;
                  end
                  @(posedge clk); #1 start = 1'b0;
                  if (!bus.desc_valid || snap() != d) stab_bad++;
               end
            end
            bus.desc_ready = 1'b1;
            if (stall > 0 && ncap[job] == 1) bus.op_done = 1'b1;
            @(posedge clk); #1 bus.desc_ready = 1'b0; bus.op_done = 1'b0;
            if (bus.desc_valid) drop_bad++;
            @(posedge clk); #1 bus.op_done = 1'b1;
            @(posedge clk); #1 bus.op_done = 1'b0;
            if (done) fin = 1;
         end else begin
            @(posedge clk); #1;
         end
      end
      chk($sformatf("finished_j%0d", job), fin, 1'b1);
      chk($sformatf("busy_u1_j%0d", job), busy, 1'b0);
      chk($sformatf("irq_u1_j%0d", job), irq, exp_irq);
      chk($sformatf("count_j%0d", job), ncap[job], exp_cnt);
      chk($sformatf("drop_j%0d", job), drop_bad, 0);
      if (stall > 0) chk($sformatf("stable_j%0d", job), stab_bad, 0);
      @(posedge clk); #1;
      chk($sformatf("irq_once_j%0d", job), irq_cnt - irq0, exp_irq ? 1 : 0);
      chk($sformatf("done_sticky_j%0d", job), done, 1'b1);
   endtask

   task automatic bad_start(input string nm);
      int seen = 0;
      int irq0;
      irq0 = irq_cnt;
      pulse_start();
      chk({nm, "_err"}, error, 1'b1);
      chk({nm, "_irq"}, irq, 1'b1);
      chk({nm, "_done_clr"}, done, 1'b0);
      for (int i = 0; i < 10; i++) begin
         if (bus.desc_valid || busy) seen++;
         @(posedge clk); #1;
      end
      chk({nm, "_quiet"}, seen, 0);
      chk({nm, "_irq_once"}, irq_cnt - irq0, 1);
   endtask

   initial begin
      int nload_a;
      bus.desc_ready = 1'b0;
      bus.op_done = 1'b0;

      //         n  k  m  t  bm upd ien  base_a     base_b     base_c     str_a str_b str_c cnt
      cfgs[0] = '{4, 4, 4, 4, 4, 1, 1, 32'h1000, 32'h2000, 32'h3000, 4, 4, 4, 4};
      cfgs[1] = '{8, 8, 8, 4, 4, 0, 0, 32'h1000, 32'h2000, 32'h3000, 8, 32, 8, 20};
      cfgs[2] = '{4, 4, 6, 4, 4, 1, 1, 32'h1000, 32'h2000, 32'h3000, 4, 4, 16, 8};

      foreach (exps[i]) exps.delete(i);
      for (int j = 0; j < 5; j++) begin
         if (j == 0 || j == 3 || j == 4) begin
            add_exp(j, 0, mk(2'd0, 32'h1000, 4, 4, 4));
            add_exp(j, 1, mk(2'd1, 32'h2000, 4, 4, 4));
            add_exp(j, 2, mk(2'd2, 32'h0,    0, 4, 4));
            add_exp(j, 3, mk(2'd3, 32'h3000, 4, 4, 4));
         end
      end
      add_exp(1, 0,  mk(2'd1, 32'h2000, 32, 4, 4));
      add_exp(1, 1,  mk(2'd2, 32'h0,    0,  4, 4));
      add_exp(1, 7,  mk(2'd1, 32'h2084, 32, 4, 4));
      add_exp(1, 14, mk(2'd3, 32'h3020, 8,  4, 4));
      add_exp(1, 15, mk(2'd1, 32'h2004, 32, 4, 4));
      add_exp(1, 17, mk(2'd1, 32'h2084, 32, 4, 4));
      add_exp(1, 19, mk(2'd3, 32'h3024, 8,  4, 4));
      add_exp(2, 0, mk(2'd0, 32'h1000, 4,  4, 4));
      add_exp(2, 1, mk(2'd1, 32'h2000, 4,  4, 4));
      add_exp(2, 2, mk(2'd2, 32'h0,    0,  4, 4));
      add_exp(2, 3, mk(2'd3, 32'h3000, 16, 4, 4));
      add_exp(2, 4, mk(2'd0, 32'h1010, 4,  2, 4));
      add_exp(2, 5, mk(2'd1, 32'h2000, 4,  4, 4));
      add_exp(2, 6, mk(2'd2, 32'h0,    0,  2, 4));
      add_exp(2, 7, mk(2'd3, 32'h3040, 16, 2, 4));

      // Reset values
      #3;
      chk("rst_valid", bus.desc_valid, 1'b0);
      chk("rst_status", {busy, done, error, irq}, 4'b0);
      chk("rst_desc", snap(), '0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_status", {busy, done, error, irq, bus.desc_valid}, 5'b0);

      // Single-tile job, then an 8x8x8 job without LOAD_A
      apply_cfg(0);
      run_job(0, 0, 1'b0, cfgs[0].cnt, 1'b1);
      apply_cfg(1);
      run_job(1, 0, 1'b0, cfgs[1].cnt, 1'b0);
      nload_a = 0;
      for (int i = 0; i < 20; i++) if (cap[1][i].ty == 2'd0) nload_a++;
      chk("no_load_a_j1", nload_a, 0);

      // Invalid starts: K=0, then tile larger than MAX_TILE
      apply_cfg(0);
      cfg_k = 16'd0;
      bad_start("bad_k0");
      apply_cfg(0);
      cfg_tile_size = 16'd17;
      bad_start("bad_t17");

      // Ragged m edge; also clears the error from the invalid starts
      apply_cfg(2);
      run_job(2, 0, 1'b0, cfgs[2].cnt, 1'b1);

      // Back-pressure for 5 cycles with a second start and a config write while busy
      apply_cfg(0);
      run_job(3, 5, 1'b1, cfgs[0].cnt, 1'b1);
      apply_cfg(0);

      // Reset while waiting for op_done
      pulse_start();
      @(posedge clk); #1 bus.desc_ready = 1'b1;
      @(posedge clk); #1 bus.desc_ready = 1'b0;
      chk("wait_busy", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_status", {busy, done, error, irq, bus.desc_valid}, 5'b0);
      chk("midrst_desc", snap(), '0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("midrst_idle", {busy, bus.desc_valid}, 2'b0);
      run_job(4, 0, 1'b0, cfgs[0].cnt, 1'b1);

      // Descriptor table comparison
      foreach (exps[i]) begin
         chk($sformatf("desc_j%0d_i%0d", exps[i].job, exps[i].idx),
             cap[exps[i].job][exps[i].idx], exps[i].d);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
